fnd_scan_driver: RTL
====================

Name: fnd_scan_driver

Overview:
- Downstream display stage of `pipeline`. It consumes a 32-bit value plus decimal-point mask and time-multiplexes it onto the 8-digit seven-segment display.
- Drives the board-level `digit` (common select) and `fnd` (segment) buses.
- Holds a shadow copy of the value so the pipeline can update it at any cycle without tearing a frame mid-digit.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays selected. Legal range 2..2^20. Benches use 4.
- LZ_BLANK_EN, 1: 1 = the leading-zero blanking logic is instantiated; 0 = the `blank_lz` input is ignored.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  32  value to display; nibble k goes to digit k, with digit 0 the rightmost.
- dp_in  input  8  decimal-point mask; bit k = 1 lights the DP of digit k.
- data_valid  input  1  one-cycle strobe; captures data_in/dp_in into the shadow registers.
- blank_lz  input  1  1 = blank leading zero digits.
- digit  output  8  one-hot, active-low digit select.
- fnd  output  8  active-low segments, ordered {dp,g,f,e,d,c,b,a}.
- frame_done  output  1  one-cycle pulse at the end of each full 8-digit scan.

Behaviour:
- Reset (synchronous, on the clk edge with reset=1):
  - shadow_val=0, shadow_dp=0.
  - Divider count=0, scan idx=0.
  - digit=8'hFF (all off), fnd=8'hFF, frame_done=0.
  - Reset asserted mid-scan aborts the scan; the display blanks on that same edge.
- Capture: on an edge with data_valid=1, shadow_val<=data_in and shadow_dp<=dp_in. Outputs use the new shadow from the following edge (latency 1). No handshake; every strobe is accepted. Back-to-back strobes keep only the last value.
- Divider:
  - count runs 0..REFRESH_DIV-1.
  - At count==REFRESH_DIV-1: count<=0 and idx<=(idx+1) mod 8, wrapping 7→0.
- frame_done<=1 on the edge where idx wraps 7→0; otherwise 0.
- Output register, updated every non-reset edge from the current idx and shadow:
  - digit<=~(8'b1<<idx).
  - fnd<=~{shadow_dp[idx], seg7(shadow_val[4*idx+:4])}.
  - First active select after reset release: digit=8'hFE, one edge after reset deasserts.
- seg7 table (active-high gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading-zero blanking (blank_lz=1 and LZ_BLANK_EN=1):
  - msd = index of the highest nonzero nibble of shadow_val; msd=0 if shadow_val==0.
  - Digits with idx>msd output fnd=~{shadow_dp[idx],7'b0}, i.e. segments off but DP still honoured. digit is still driven.
  - Digit 0 is never blanked, so a zero value shows a single "0".
- blank_lz and data_valid may change at any cycle; the effect appears on the next output-register update. No glitch filtering is required.
- Divider width is ceil(log2(REFRESH_DIV)). No arithmetic overflow beyond the compare-and-clear.

Test Plan:
- Reset check: REFRESH_DIV=4, hold reset 5 cycles → digit=FF, fnd=FF, frame_done=0. Release reset → next edge digit=FE, fnd=C0 (value 0 → "0").
- Scan order: strobe data_in=32'h76543210, dp_in=0, blank_lz=0 →
  - digit steps FE, FD, FB, F7, EF, DF, BF, 7F, each held 4 cycles.
  - fnd steps C0, F9, A4, B0, 99, 92, 82, F8.
  - frame_done pulses once per 32 cycles on the 7→0 wrap.
- Hex and DP: data_in=32'hFEDCBA98, dp_in=8'h01 →
  - digit0 fnd=~{1,7F}=00; digit1=~6F=90.
  - digits 2..7 give 88, 83, C6, A1, 86, 8E.
- Blanking: data_in=32'h00000A05, blank_lz=1 → digit0=92, digit1=C0, digit2=88, digits 3..7 fnd=FF. Same input with dp_in=8'h80 → digit7 fnd=7F.
- Update timing: strobe a new value while idx=3 mid-dwell → fnd changes on the very next edge, without waiting for the frame. Two consecutive strobes with 1 then 2 → only 2 is displayed.
- Reset mid-operation: assert reset while idx=5, count=2 → same edge gives digit=FF, fnd=FF. After release, the scan restarts at digit FE with the shadow cleared (fnd=C0).

Source files
------------

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: time-multiplexed 8-digit seven-segment display driver.
// A shadow copy of the value/DP mask is scanned one digit per REFRESH_DIV clocks,
// with optional leading-zero blanking and a frame_done pulse per full scan.
module fnd_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          LZ_BLANK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        data_valid,
  input  logic        blank_lz,
  output logic [7:0]  digit,
  output logic [7:0]  fnd,
  output logic        frame_done
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(REFRESH_DIV - 1);

  logic [31:0]   r_shadow_val;
  logic [7:0]    r_shadow_dp;
  logic [CW-1:0] r_count;
  logic [2:0]    r_idx;
  logic [7:0]    r_digit;
  logic [7:0]    r_fnd;
  logic          r_frame_done;

  logic [2:0]    w_msd;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic [6:0]    w_seg;
  logic          w_tick;

  // Active-high gfedcba pattern for a hex nibble
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  // Most significant nonzero nibble of the shadow value (0 when value is zero)
  always_comb begin
    w_msd = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (r_shadow_val[4*i +: 4] != 4'h0) w_msd = 3'(i);
    end
  end

  // Segment pattern for the digit currently selected
  always_comb begin
    w_nib   = r_shadow_val[{r_idx, 2'b00} +: 4];
    w_blank = LZ_BLANK_EN && blank_lz && (r_idx > w_msd);
    w_seg   = w_blank ? 7'h00 : seg7(w_nib);
    w_tick  = (r_count == LAST_COUNT);
  end

  // Shadow capture of the incoming value and DP mask
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
    end else if (data_valid) begin
      r_shadow_val <= data_in;
      r_shadow_dp  <= dp_in;
    end
  end

  // Refresh divider and digit index, with frame pulse on the 7->0 wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_tick && (r_idx == 3'd7);
      if (w_tick) begin
        r_count <= '0;
        r_idx   <= r_idx + 3'd1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Registered active-low digit select and segment outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digit <= '1;
      r_fnd   <= '1;
    end else begin
      r_digit <= ~(8'b1 << r_idx);
      r_fnd   <= ~{r_shadow_dp[r_idx], w_seg};
    end
  end

  assign digit      = r_digit;
  assign fnd        = r_fnd;
  assign frame_done = r_frame_done;

endmodule
